// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline types: opcode/ALU encodings plus the memory-port arbiter
// state and owner encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_WAIT = 2'd1,
    DATA_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_t;

  localparam int STARVE_CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_priority_sel.sv
// Data-first priority select with a saturating fetch-starvation counter
// that hands the port to fetch once data has won STARVE_LIMIT times in a row.
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic                    d_req,
  input  logic                    idle,
  input  logic                    accept,
  output owner_t                  sel,
  output logic [STARVE_CNT_W-1:0] starve_cnt
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    sel = OWN_DATA;
    if (if_req && (!d_req || starve_cnt == LIMIT)) sel = OWN_FETCH;
  end

  // Counter only moves in IDLE; a WAIT state freezes the fetch's history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!if_req || (accept && sel == OWN_FETCH))
        starve_cnt <= '0;
      else if (accept && starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, single outstanding
// read; writes retire on acceptance.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  arb_state_t              state, state_nxt;
  owner_t                  sel;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    accept;
  logic                    idle;

  assign idle   = (state == IDLE);
  assign accept = reset_n && idle && (if_req || d_req) && mem_ready;

  arb_priority_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .d_req      (d_req),
    .idle       (idle),
    .accept     (accept),
    .sel        (sel),
    .starve_cnt (starve_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Outputs are gated by reset_n so the whole port reads zero while held in reset.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          mem_req = if_req | d_req;
          if (sel == OWN_FETCH) begin
            mem_addr = if_addr;
          end else begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_req & d_we;
          end
          if (accept) begin
            if (sel == OWN_FETCH) begin
              if_gnt    = 1'b1;
              state_nxt = FETCH_WAIT;
            end else begin
              d_gnt = 1'b1;
              if (!d_we) state_nxt = DATA_WAIT;
            end
          end
        end
        FETCH_WAIT: begin
          busy = 1'b1;
          if (mem_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
            state_nxt = IDLE;
          end
        end
        DATA_WAIT: begin
          busy = 1'b1;
          if (mem_rvalid) begin
            d_rvalid  = 1'b1;
            d_rdata   = mem_rdata;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: inputs change on the falling edge, outputs are checked 1ns
// later, well clear of the rising edge.
module tb_mem_port_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, d_req, d_we, mem_ready, mem_rvalid;
  logic [DW-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic fall();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h100; d_addr = 32'h40; d_wdata = 32'h5; mem_ready = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    // reset: every output held at zero even with live requests
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_gnts", {30'd0, if_gnt, d_gnt}, 0);
    chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 0);
    chk("rst_mem_we_busy", {30'd0, mem_we, busy}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    fall();
    if_req = 0; d_req = 0; d_we = 0; mem_rvalid = 0; mem_ready = 0;
    fall();
    reset_n = 1'b1;

    // fetch read
    fall();
    if_req = 1; if_addr = 32'h100; mem_ready = 1; #1;
    chk("fetch_mem_req", 32'(mem_req), 1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    chk("fetch_if_gnt", 32'(if_gnt), 1);
    chk("fetch_d_gnt", 32'(d_gnt), 0);
    fall();
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00A0_0093; #1;
    chk("fetch_busy", 32'(busy), 1);
    chk("fetch_wait_mem_req", 32'(mem_req), 0);
    chk("fetch_if_rvalid", 32'(if_rvalid), 1);
    chk("fetch_if_rdata", if_rdata, 32'h00A0_0093);
    chk("fetch_d_rvalid", 32'(d_rvalid), 0);
    fall();
    mem_rvalid = 0; #1;
    chk("fetch_back_idle", 32'(busy), 0);

    // rvalid in IDLE is ignored
    fall();
    mem_rvalid = 1; mem_rdata = 32'h1111_2222; #1;
    chk("idle_rvalid_ignored", {30'd0, if_rvalid, d_rvalid}, 0);
    fall();
    mem_rvalid = 0;

    // simultaneous: data first
    fall();
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000; mem_ready = 1; #1;
    chk("sim_d_gnt", 32'(d_gnt), 1);
    chk("sim_if_gnt", 32'(if_gnt), 0);
    chk("sim_mem_addr", mem_addr, 32'h2000);
    chk("sim_mem_we", 32'(mem_we), 0);
    fall();
    d_req = 0; #1;
    chk("dwait_no_gnt", {30'd0, if_gnt, mem_req}, 0);
    chk("dwait_busy", 32'(busy), 1);
    fall();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_0001; #1;
    chk("dwait_d_rvalid", 32'(d_rvalid), 1);
    chk("dwait_d_rdata", d_rdata, 32'hCAFE_0001);
    chk("dwait_if_rvalid", 32'(if_rvalid), 0);

    // stall: fetch pending, memory not ready for 3 cycles
    fall();
    mem_rvalid = 0; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) fall();
      #1;
      chk($sformatf("stall_if_gnt_%0d", i), 32'(if_gnt), 0);
      chk($sformatf("stall_mem_req_%0d", i), 32'(mem_req), 1);
      chk($sformatf("stall_mem_addr_%0d", i), mem_addr, 32'h104);
    end
    fall();
    mem_ready = 1; #1;
    chk("stall_release_if_gnt", 32'(if_gnt), 1);
    fall();
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013; #1;
    chk("stall_if_rdata", if_rdata, 32'h0000_0013);

    // write completes on acceptance
    fall();
    mem_rvalid = 0; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; mem_ready = 1; #1;
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_mem_addr", mem_addr, 32'h40);
    chk("wr_d_gnt", 32'(d_gnt), 1);
    fall();
    d_req = 0; d_we = 0; #1;
    chk("wr_stays_idle", 32'(busy), 0);
    chk("wr_no_rvalid", 32'(d_rvalid), 0);

    // starvation: 4 data writes, then fetch, then data resumes
    fall();
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 1; mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) fall();
      d_addr = 32'h80 + 32'(i * 4); #1;
      chk($sformatf("starve_d_gnt_%0d", i), {30'd0, if_gnt, d_gnt}, 32'b01);
    end
    fall();
    #1;
    chk("starve_if_gnt", {30'd0, if_gnt, d_gnt}, 32'b10);
    chk("starve_fetch_addr", mem_addr, 32'h200);
    chk("starve_fetch_we", 32'(mem_we), 0);
    fall();
    mem_rvalid = 1; mem_rdata = 32'h0000_0067; #1;
    chk("starve_wait_no_gnt", {30'd0, if_gnt, d_gnt}, 0);
    chk("starve_if_rvalid", 32'(if_rvalid), 1);
    fall();
    mem_rvalid = 0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) fall();
      #1;
      chk($sformatf("resume_d_gnt_%0d", i), {30'd0, if_gnt, d_gnt}, 32'b01);
    end
    fall();
    if_req = 0; d_req = 0; d_we = 0;

    // reset while a data read is outstanding
    fall();
    d_req = 1; d_addr = 32'h300; #1;
    chk("rst_dr_d_gnt", 32'(d_gnt), 1);
    fall();
    d_req = 0; #1;
    chk("rst_dr_busy", 32'(busy), 1);
    fall();
    reset_n = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0; #1;
    chk("rst_dr_cleared", {29'd0, busy, d_rvalid, mem_req}, 0);
    chk("rst_dr_rdata", d_rdata, 0);
    fall();
    reset_n = 1; #1;
    chk("rst_dr_stale_rvalid", {30'd0, d_rvalid, busy}, 0);
    fall();
    mem_rvalid = 0; d_req = 1; d_addr = 32'h304; #1;
    chk("rst_dr_next_gnt", 32'(d_gnt), 1);
    chk("rst_dr_next_addr", mem_addr, 32'h304);
    fall();
    d_req = 0;
    fall();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, as the width of address and data buses.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, as the maximum number of consecutive data grants allowed while a fetch is waiting.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Ports if_req (in, 1), if_addr (in, DATA_WIDTH): instruction-fetch read request and its address.
REQ-006 Ports if_gnt (out, 1), if_rvalid (out, 1), if_rdata (out, DATA_WIDTH): fetch accept strobe, read-data strobe and read data.
REQ-007 Ports d_req (in, 1), d_we (in, 1), d_addr (in, DATA_WIDTH), d_wdata (in, DATA_WIDTH): data-stage request, write enable, address and write data.
REQ-008 Ports d_gnt (out, 1), d_rvalid (out, 1), d_rdata (out, DATA_WIDTH): data accept strobe, read-data strobe and read data.
REQ-009 Ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, DATA_WIDTH), mem_wdata (out, DATA_WIDTH): the single shared memory port.
REQ-010 Ports mem_ready (in, 1), mem_rvalid (in, 1), mem_rdata (in, DATA_WIDTH): memory accept strobe, read-data strobe and read data.
REQ-011 Port busy, out, 1: high while a read is outstanding.

Function
REQ-012 The FSM SHALL have three states: IDLE, FETCH_WAIT and DATA_WAIT.
REQ-013 In IDLE, the arbiter SHALL drive mem_req = if_req | d_req, combinationally, with mem_addr, mem_we and mem_wdata taken from the selected requester.
REQ-014 Selection: data SHALL win unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch SHALL win.
REQ-015 Acceptance SHALL occur when mem_req & mem_ready in IDLE; in that same cycle the winner's gnt SHALL pulse for 1 cycle and the loser's gnt SHALL stay 0.
REQ-016 An accepted read SHALL move IDLE->FETCH_WAIT (fetch) or IDLE->DATA_WAIT (data).
REQ-017 An accepted write (d_we=1) SHALL be complete on acceptance: state stays IDLE, no d_rvalid is produced.
REQ-018 In FETCH_WAIT or DATA_WAIT, mem_req SHALL be 0 and no new grant SHALL be issued (one outstanding transaction only).
REQ-019 On mem_rvalid in a WAIT state, the owner's rvalid SHALL pulse in the same cycle with rdata = mem_rdata, and the state SHALL return to IDLE on the next edge.
REQ-020 The non-owner's rvalid SHALL be 0; mem_rvalid in IDLE SHALL be ignored.
REQ-021 starve_cnt (3 bits, saturating) SHALL increment on a data grant while if_req=1, and clear on a fetch grant or whenever if_req=0 in IDLE.
REQ-022 The combinational path from req to mem_req SHALL be valid only in IDLE; requester inputs SHALL be held stable by requesters until gnt.
REQ-023 busy SHALL be 1 exactly in FETCH_WAIT or DATA_WAIT.
REQ-024 Minimum read latency SHALL be: grant in cycle N, rvalid in cycle N+1 or later; back-to-back reads SHALL be spaced at least 2 cycles apart.

Reset
REQ-025 Asserting reset_n=0 SHALL asynchronously force state=IDLE and starve_cnt=0.
REQ-026 During reset, all outputs SHALL be 0: gnts, rvalids, mem_req, mem_we, busy, addr and data buses.
REQ-027 Reset mid-transaction SHALL abandon the outstanding read; a later mem_rvalid in IDLE SHALL be ignored.

Structure
REQ-028 The arb_state_t enum (IDLE, FETCH_WAIT, DATA_WAIT) and the owner encoding SHALL live in the shared pipeline package alongside opcode_t and alu_op_t.
REQ-029 Priority selection plus starve_cnt SHALL be one sub-module, arb_priority_sel; the FSM and muxing SHALL live in mem_port_arbiter.

Verification
REQ-030 Fetch read: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid one cycle later with 0x00A00093 -> if_gnt pulse, then if_rvalid=1 with if_rdata=0x00A00093.
REQ-031 Simultaneous requests: if_req=d_req=1, d_addr=0x2000, d_we=0 -> d_gnt first, mem_addr=0x2000, if_gnt=0.
REQ-032 Starvation: if_req held high, d_req high for 6 requests -> 4 data grants, then if_gnt, then data resumes.
REQ-033 Write: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready=1 -> mem_we=1, d_gnt pulse, state stays IDLE, no d_rvalid.
REQ-034 Stall: mem_ready=0 for 3 cycles with if_req=1 -> no if_gnt, mem_req held with stable address.
REQ-035 Reset in DATA_WAIT: reset_n=0, then a mem_rvalid arrives -> all outputs 0, no d_rvalid, next request is granted normally.
